// File: rtl/axi_crossbar_addr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_crossbar_addr_arb_if
// Description : Bundle of the address-channel arbitration signals of one
//               crossbar master port. It carries the per-source request
//               side, the address valid/ready pair toward the master port,
//               the grant select outputs, the completion pulse and the
//               outstanding-transaction count.
//
//               Modports:
//                 master : the arbiter. It consumes requests, completions
//                          and aready. It drives grants, avalid, s_req_ready
//                          and the issue count.
//                 slave  : the surrounding environment, with all directions
//                          mirrored.
//
//               Signals:
//                 s_req_valid      [S_COUNT]    per-source request valid
//                 s_req_qos        [S_COUNT*4]  per-source aqos, n at [n*4+:4]
//                 s_req_ready      [S_COUNT]    per-source handshake acknowledge
//                 m_axi_avalid     [1]          address valid to master port
//                 m_axi_aready     [1]          master port ready
//                 m_grant          [S_COUNT]    one-hot granted source
//                 m_grant_encoded  [GW]         binary index of granted source
//                 m_cpl_valid      [1]          one transaction completed
//                 m_issue_count    [CW]         outstanding transaction count
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_crossbar_addr_arb_if #(
  parameter int          S_COUNT = 4,
  parameter int unsigned M_ISSUE = 32'd4
);

  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int CW = $clog2(M_ISSUE + 1);

  logic [S_COUNT-1:0]   s_req_valid;
  logic [S_COUNT*4-1:0] s_req_qos;
  logic [S_COUNT-1:0]   s_req_ready;
  logic                 m_axi_avalid;
  logic                 m_axi_aready;
  logic [S_COUNT-1:0]   m_grant;
  logic [GW-1:0]        m_grant_encoded;
  logic                 m_cpl_valid;
  logic [CW-1:0]        m_issue_count;

  modport master (
    input  s_req_valid,
    input  s_req_qos,
    input  m_axi_aready,
    input  m_cpl_valid,
    output s_req_ready,
    output m_axi_avalid,
    output m_grant,
    output m_grant_encoded,
    output m_issue_count
  );

  modport slave (
    output s_req_valid,
    output s_req_qos,
    output m_axi_aready,
    output m_cpl_valid,
    input  s_req_ready,
    input  m_axi_avalid,
    input  m_grant,
    input  m_grant_encoded,
    input  m_issue_count
  );

endinterface
`default_nettype wire

// File: rtl/axi_crossbar_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi_crossbar_addr_arb
// Description : Address-channel arbiter for one crossbar master port (AW or
//               AR). It picks one requesting source at a time. The choice is
//               by highest aqos (when QOS_ENABLE) with round-robin
//               tie-breaking. The grant is held until the address handshake
//               completes. The arbiter also keeps the number of outstanding
//               transactions at or below M_ISSUE.
//
//               Ports:
//                 clk     : clock
//                 rst     : synchronous, active-high reset
//                 arb_if  : axi_crossbar_addr_arb_if.master. It carries the
//                           requests, qos, s_req_ready, avalid/aready, the
//                           grant select, completions and the issue count.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_crossbar_addr_arb #(
  parameter int          S_COUNT    = 4,
  parameter int unsigned M_ISSUE    = 32'd4,
  parameter bit          QOS_ENABLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_crossbar_addr_arb_if.master arb_if
);

  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int CW = $clog2(M_ISSUE + 1);

  // After reset the last winner is the top index, so the round-robin scan
  // starts at source 0.
  localparam logic [GW-1:0] c_last_rst  = GW'(S_COUNT - 1);
  localparam logic [CW-1:0] c_issue_max = CW'(M_ISSUE);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [S_COUNT-1:0] r_grant;
  logic [GW-1:0]      r_grant_enc;
  logic [GW-1:0]      r_last;
  logic [CW-1:0]      r_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [S_COUNT-1:0] w_grant_nxt;
  logic [GW-1:0]      w_enc_nxt;
  logic [GW-1:0]      w_last_nxt;
  logic [CW-1:0]      w_count_nxt;

  logic [3:0]         w_max_qos;
  logic [S_COUNT-1:0] w_cand;
  logic               w_found;
  logic [GW-1:0]      w_win_idx;
  logic [GW-1:0]      w_scan_idx;
  logic [S_COUNT-1:0] w_win_onehot;
  logic               w_limit;
  logic               w_hs;
  logic               w_cpl_eff;

  // --------------------------------------------------------------------------
  // Candidate set. With QOS enabled, only valid sources that share the
  // highest valid qos compete. Otherwise every valid source competes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_max_qos = '0;
    w_cand    = '0;
    for (int n = 0; n < S_COUNT; n++) begin
      if (arb_if.s_req_valid[n] && (arb_if.s_req_qos[n*4 +: 4] > w_max_qos)) begin
        w_max_qos = arb_if.s_req_qos[n*4 +: 4];
      end
    end
    for (int n = 0; n < S_COUNT; n++) begin
      w_cand[n] = arb_if.s_req_valid[n] &&
                  (!QOS_ENABLE || (arb_if.s_req_qos[n*4 +: 4] == w_max_qos));
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pick. The scan starts one past the last winner and wraps at
  // S_COUNT. The first candidate found wins. w_found is set exactly when at
  // least one source is valid.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found    = 1'b0;
    w_win_idx  = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      w_scan_idx = GW'((int'(r_last) + k) % S_COUNT);
      if (!w_found && w_cand[w_scan_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan_idx;
      end
    end
  end

  assign w_win_onehot = S_COUNT'(1) << w_win_idx;

  // A completion in the same cycle frees a slot. Arbitration can therefore
  // proceed even while the count sits at the limit.
  assign w_limit = (r_count >= c_issue_max) && !arb_if.m_cpl_valid;

  assign w_hs      = (r_state == ST_GRANT) && arb_if.m_axi_aready;
  assign w_cpl_eff = arb_if.m_cpl_valid && (r_count != '0);

  // --------------------------------------------------------------------------
  // FSM next-state and grant registers
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_enc_nxt   = r_grant_enc;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found && !w_limit) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_win_onehot;
          w_enc_nxt   = w_win_idx;
        end
      end
      ST_GRANT: begin
        // Requests are not looked at here. The grant stays frozen until
        // the master accepts the address.
        if (arb_if.m_axi_aready) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_grant_enc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outstanding-transaction counter. A handshake and a completion in the
  // same cycle cancel out. A completion at zero is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    if (w_hs && !w_cpl_eff) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_hs && w_cpl_eff) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_enc <= '0;
      r_last      <= c_last_rst;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_enc <= w_enc_nxt;
      r_last      <= w_last_nxt;
      r_count     <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. s_req_ready is masked during reset. A grant that reset is
  // tearing down therefore never acknowledges its requester.
  // --------------------------------------------------------------------------
  assign arb_if.m_axi_avalid  = (r_state == ST_GRANT);
  assign arb_if.m_grant       = r_grant;
  assign arb_if.s_req_ready   = r_grant & {S_COUNT{arb_if.m_axi_aready & ~rst}};
  assign arb_if.m_issue_count = r_count;

  generate
    if (S_COUNT == 1) begin : g_enc_single
      assign arb_if.m_grant_encoded = '0;
    end else begin : g_enc_multi
      assign arb_if.m_grant_encoded = r_grant_enc;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_crossbar_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_crossbar_addr_arb
// Description : Randomized bench for axi_crossbar_addr_arb. It runs two
//               instances, one with QOS_ENABLE=1 and one with QOS_ENABLE=0,
//               both with S_COUNT=4 and M_ISSUE=2. The driver keeps a
//               behavioural model of each port. It pushes the expected
//               per-cycle state and the expected grant order into
//               scoreboards. Per-instance monitors pop those entries and
//               compare them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_crossbar_addr_arb;

  localparam int          S  = 4;
  localparam int unsigned MI = 32'd2;
  localparam int          NI = 2;
  localparam int          NPH = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [S-1:0]   d_valid  [NI];
  logic [4*S-1:0] d_qos    [NI];
  logic           d_aready [NI];
  logic           d_cpl    [NI];

  typedef struct {
    bit avalid;
    int cnt;
    bit fresh;
  } cyc_t;

  int   gq [NI][$];
  cyc_t cq [NI][$];

  bit m_busy  [NI];
  int m_gidx  [NI];
  int m_last  [NI];
  int m_cnt   [NI];
  bit m_fresh [NI];

  int n_vec = 0;
  int n_err = 0;

  axi_crossbar_addr_arb_if #(.S_COUNT(S), .M_ISSUE(MI)) bus [NI] ();

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Highest valid qos wins (when enabled). Ties are broken by the first
  // candidate at or after last+1, with wrap-around.
  function automatic int pick(input bit qen, input logic [S-1:0] v,
                              input logic [4*S-1:0] qv, input int last);
    int mx;
    int n;
    mx = -1;
    for (int j = 0; j < S; j++) begin
      if (v[j] && (int'(qv[j*4 +: 4]) > mx)) mx = int'(qv[j*4 +: 4]);
    end
    for (int k = 1; k <= S; k++) begin
      n = (last + k) % S;
      if (v[n] && (!qen || (int'(qv[n*4 +: 4]) == mx))) return n;
    end
    return -1;
  endfunction

  // Applies the inputs that were present during the cycle that just ended.
  task automatic model_step(input int i);
    bit hs;
    bit ce;
    int w;
    if (rst) begin
      if (m_busy[i] && (gq[i].size() != 0)) void'(gq[i].pop_back());
      m_busy[i]  = 1'b0;
      m_gidx[i]  = 0;
      m_last[i]  = S - 1;
      m_cnt[i]   = 0;
      m_fresh[i] = 1'b1;
      return;
    end
    hs = m_busy[i] && d_aready[i];
    ce = d_cpl[i] && (m_cnt[i] > 0);
    if (m_busy[i]) begin
      if (d_aready[i]) begin
        m_busy[i] = 1'b0;
        m_last[i] = m_gidx[i];
      end
    end else if ((d_valid[i] != '0) && !((m_cnt[i] >= int'(MI)) && !d_cpl[i])) begin
      w = pick(i == 0, d_valid[i], d_qos[i], m_last[i]);
      m_busy[i]  = 1'b1;
      m_gidx[i]  = w;
      m_fresh[i] = 1'b0;
      gq[i].push_back(w);
    end
    if (hs && !ce) m_cnt[i]++;
    else if (ce && !hs) m_cnt[i]--;
  endtask

  task automatic gen_inputs(input int i, input int ph);
    int qlv [4] = '{0, 2, 9, 15};
    int lvl;
    d_cpl[i] = 1'b0;
    case (ph)
      0: begin
        d_valid[i]  = '0;
        d_qos[i]    = 16'($urandom);
        d_aready[i] = 1'($urandom_range(0, 1));
      end
      1: begin
        lvl         = $urandom_range(0, 15);
        d_valid[i]  = '1;
        for (int n = 0; n < S; n++) d_qos[i][n*4 +: 4] = 4'(lvl);
        d_aready[i] = 1'b1;
        d_cpl[i]    = (m_cnt[i] > 0);
      end
      2, 4, 5: begin
        d_valid[i] = 4'($urandom);
        for (int n = 0; n < S; n++) d_qos[i][n*4 +: 4] = 4'(qlv[$urandom_range(0, 3)]);
        if (ph == 4) d_aready[i] = ($urandom_range(0, 6) == 0);
        else         d_aready[i] = ($urandom_range(0, 9) < 6);
        if (m_cnt[i] > 0) d_cpl[i] = ($urandom_range(0, 9) < 3);
        else if (!(m_busy[i] && d_aready[i])) d_cpl[i] = ($urandom_range(0, 9) < 2);
      end
      3: begin
        d_valid[i]  = 4'($urandom_range(1, 15));
        d_qos[i]    = 16'($urandom);
        d_aready[i] = 1'b1;
        d_cpl[i]    = (m_cnt[i] > 0) && ($urandom_range(0, 19) == 0);
      end
      default: begin
        d_valid[i]  = '0;
        d_aready[i] = 1'b1;
      end
    endcase
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign bus[gi].s_req_valid  = d_valid[gi];
    assign bus[gi].s_req_qos    = d_qos[gi];
    assign bus[gi].m_axi_aready = d_aready[gi];
    assign bus[gi].m_cpl_valid  = d_cpl[gi];

    axi_crossbar_addr_arb #(
      .S_COUNT    (S),
      .M_ISSUE    (MI),
      .QOS_ENABLE ((gi == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus[gi])
    );

    initial begin : mon
      cyc_t c;
      int   e;
      forever begin
        @(negedge clk);
        if (cq[gi].size() != 0) begin
          c = cq[gi].pop_front();
          chk("avalid", gi, 32'(bus[gi].m_axi_avalid), 32'(c.avalid));
          chk("issue_count", gi, 32'(bus[gi].m_issue_count), c.cnt);
          if (c.fresh) chk("grant_after_reset", gi, 32'(bus[gi].m_grant), 0);
          if (bus[gi].m_axi_avalid && bus[gi].m_axi_aready && !rst) begin
            if (gq[gi].size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL handshake inst%0d t=%0t: got handshake grant %0h expected no grant",
                       gi, $time, bus[gi].m_grant);
            end else begin
              e = gq[gi].pop_front();
              chk("grant", gi, 32'(bus[gi].m_grant), 32'(1) << e);
              chk("grant_encoded", gi, 32'(bus[gi].m_grant_encoded), e);
              chk("s_req_ready", gi, 32'(bus[gi].s_req_ready), 32'(1) << e);
            end
          end else begin
            chk("s_req_ready_quiet", gi, 32'(bus[gi].s_req_ready), 0);
            if (bus[gi].m_axi_avalid && (gq[gi].size() != 0))
              chk("grant_hold", gi, 32'(bus[gi].m_grant), 32'(1) << gq[gi][0]);
          end
        end
      end
    end
  end

  initial begin : drv
    int   plen [NPH] = '{14, 40, 400, 300, 300, 400, 8};
    cyc_t rec;
    for (int i = 0; i < NI; i++) begin
      d_valid[i]  = '0;
      d_qos[i]    = '0;
      d_aready[i] = 1'b0;
      d_cpl[i]    = 1'b0;
      m_busy[i]   = 1'b0;
      m_gidx[i]   = 0;
      m_last[i]   = S - 1;
      m_cnt[i]    = 0;
      m_fresh[i]  = 1'b1;
    end
    for (int ph = 0; ph < NPH; ph++) begin
      for (int cyc = 0; cyc < plen[ph]; cyc++) begin
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
          model_step(i);
          rec.avalid = m_busy[i];
          rec.cnt    = m_cnt[i];
          rec.fresh  = m_fresh[i];
          cq[i].push_back(rec);
        end
        if (ph == 0)      rst = (cyc < 3);
        else if (ph == 5) rst = ($urandom_range(0, 19) == 0);
        else              rst = 1'b0;
        for (int i = 0; i < NI; i++) gen_inputs(i, ph);
      end
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("pending_grants", i, 32'(gq[i].size()), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
